// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access size codes, FSM state codes,
// and size-derived byte counts and alignment masks.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2,
        LSU_BAD  = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_RD   = 2'd1,
        LSU_WR   = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] lsu_size_bytes(input lsu_size_e size);
        case (size)
            LSU_BYTE: return 3'd1;
            LSU_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] lsu_low_mask(input lsu_size_e size);
        case (size)
            LSU_BYTE: return 2'b00;
            LSU_HALF: return 2'b01;
            default:  return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the load/store unit: extracts and extends the addressed byte/half of a read
// word, and merges store data into the addressed lane(s) of that word for read-modify-write.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  lsu_size_e   size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rd_word[{lane, 3'b000} +: 8];
        lane_half = rd_word[{lane[1], 4'b0000} +: 16];
        rdata     = rd_word;
        merged    = wdata;
        case (size)
            LSU_BYTE: begin
                rdata  = {{24{sign_ext & lane_byte[7]}}, lane_byte};
                merged = rd_word;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            LSU_HALF: begin
                rdata  = {{16{sign_ext & lane_half[15]}}, lane_half};
                merged = rd_word;
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time to a word-wide SRAM with combinational read;
// sub-word stores are done as read-modify-write because the memory writes whole words.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   LSU_IDLE | ready for a request; request fields latched on accept
//   LSU_RD   | read word from SRAM into rd_q (loads and sub-word stores)
//   LSU_WR   | one-cycle write strobe with full or merged word
//   LSU_RESP | one-cycle response pulse, then back to IDLE
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter logic [31:0] SRAM_LIMIT  = 32'h0000_00FC,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] sram_addr,
    output logic [31:0] w_sram,
    output logic        w_sram_en,
    input  logic [31:0] r_sram
);

    lsu_state_e  state_q, state_d;
    lsu_size_e   size_q, size_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_q, rd_d;
    logic [1:0]  lane_q, lane_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic        fault_q, fault_d;

    lsu_size_e   req_sz;
    logic        accept;
    logic        misalign;
    logic        req_fault;
    logic [31:0] eff_addr;
    logic [32:0] last_byte;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    // Fault decode on the incoming request; the limit check uses 33 bits so the top of the
    // address space cannot wrap back into range.
    always_comb begin
        req_sz    = lsu_size_e'(req_size);
        accept    = req_valid && (state_q == LSU_IDLE);
        misalign  = (req_addr[1:0] & lsu_low_mask(req_sz)) != 2'b00;
        eff_addr  = ALIGN_CHECK ? req_addr
                                : {req_addr[31:2], req_addr[1:0] & ~lsu_low_mask(req_sz)};
        last_byte = {1'b0, eff_addr} + {30'd0, lsu_size_bytes(req_sz)} - 33'd1;
        req_fault = (req_sz == LSU_BAD) || (ALIGN_CHECK && misalign) ||
                    (last_byte >= {1'b0, SRAM_LIMIT});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LSU_IDLE;
            size_q      <= LSU_BYTE;
            sram_addr_q <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            lane_q      <= '0;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            lane_q      <= lane_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (req_fault)                              state_d = LSU_RESP;
                    else if (!req_write || req_sz != LSU_WORD)  state_d = LSU_RD;
                    else                                        state_d = LSU_WR;
                end
            end
            LSU_RD:   state_d = write_q ? LSU_WR : LSU_RESP;
            LSU_WR:   state_d = LSU_RESP;
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        sram_addr_d = sram_addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        lane_d      = lane_q;
        signed_d    = signed_q;
        write_d     = write_q;
        fault_d     = fault_q;
        rd_d        = rd_q;
        if (accept) begin
            sram_addr_d = {eff_addr[31:2], 2'b00};
            size_d      = req_sz;
            wdata_d     = req_wdata;
            lane_d      = eff_addr[1:0];
            signed_d    = req_signed;
            write_d     = req_write;
            fault_d     = req_fault;
        end
        if (state_q == LSU_RD) begin
            rd_d = r_sram;
        end
    end

    lsu_lane_align u_lane_align (
        .rd_word  (rd_q),
        .wdata    (wdata_q),
        .lane     (lane_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .rdata    (ld_data),
        .merged   (st_word)
    );

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_fault = 1'b0;
        rsp_rdata = '0;
        w_sram_en = 1'b0;
        w_sram    = '0;
        case (state_q)
            LSU_IDLE: req_ready = 1'b1;
            LSU_WR: begin
                w_sram_en = 1'b1;
                w_sram    = st_word;
            end
            LSU_RESP: begin
                rsp_valid = 1'b1;
                rsp_fault = fault_q;
                rsp_rdata = (fault_q || write_q) ? 32'd0 : ld_data;
            end
            default: ;
        endcase
    end

    assign sram_addr = sram_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word SRAM responder, access-level reference model checked every
// cycle, and directed requests with hand-computed results.
module tb_load_store_unit;

    localparam logic [31:0] LIMIT = 32'h0000_00FC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] sram_addr;
    logic [31:0] w_sram;
    logic        w_sram_en;
    logic [31:0] r_sram;

    load_store_unit #(.SRAM_LIMIT(LIMIT), .ALIGN_CHECK(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .sram_addr  (sram_addr),
        .w_sram     (w_sram),
        .w_sram_en  (w_sram_en),
        .r_sram     (r_sram)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic init_req;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] preload(input int i);
        case (i)
            4:       return 32'h8765_43A1;
            5:       return 32'h1122_3344;
            6:       return 32'h5566_7788;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // SRAM responder: combinational read, whole-word write on the strobe.
    logic [31:0] sram [64];
    assign r_sram = sram[sram_addr[7:2]];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 64; i++) sram[i] <= preload(i);
        end else if (w_sram_en) begin
            sram[sram_addr[7:2]] <= w_sram;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected response/write per accepted access, evaluated at access level.
    logic [31:0] ref_mem [64];
    int          exp_rsp_cyc = -1;
    int          exp_wr_cyc  = -1;
    int          ready_from  = 0;
    logic [31:0] exp_rdata, exp_wr_data, exp_wr_addr;
    logic        exp_fault;
    int          acc_count = 0, rsp_count = 0, wr_count = 0;
    int          last_acc_cyc, last_rsp_cyc;
    logic [31:0] last_rdata, last_wdata;
    logic        last_fault;
    logic [31:0] rsp_log[$];
    int          acc_log[$];

    always @(negedge clk) begin : monitor
        int nb, lane;
        logic [31:0] ea, word, val, mask;
        logic [32:0] last;
        logic flt;
        if (init_req) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = preload(i);
        end
        if (!rst_n) begin
            exp_rsp_cyc = -1;
            exp_wr_cyc  = -1;
            ready_from  = 0;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
            chk("rst_sram_addr", sram_addr, 32'd0);
            chk("rst_w_sram", w_sram, 32'd0);
            chk("rst_w_sram_en", 32'(w_sram_en), 32'd0);
        end else begin
            chk("req_ready", 32'(req_ready), 32'(cyc >= ready_from));
            chk("rsp_valid", 32'(rsp_valid), 32'(cyc == exp_rsp_cyc));
            if (cyc == exp_rsp_cyc) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
            end else begin
                chk("idle_rdata", rsp_rdata, 32'd0);
                chk("idle_fault", 32'(rsp_fault), 32'd0);
            end
            if (rsp_valid) begin
                last_rdata   = rsp_rdata;
                last_fault   = rsp_fault;
                last_rsp_cyc = cyc;
                rsp_log.push_back(rsp_rdata);
                rsp_count++;
            end
            chk("w_sram_en", 32'(w_sram_en), 32'(cyc == exp_wr_cyc));
            if (cyc == exp_wr_cyc) begin
                chk("w_sram", w_sram, exp_wr_data);
                chk("wr_sram_addr", sram_addr, exp_wr_addr);
                ref_mem[exp_wr_addr[7:2]] = exp_wr_data;
            end
            if (w_sram_en) begin
                wr_count++;
                last_wdata = w_sram;
            end
            if (req_valid && req_ready) begin
                acc_count++;
                last_acc_cyc = cyc;
                acc_log.push_back(cyc);
                nb   = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
                ea   = req_addr;
                last = {1'b0, ea} + 33'(nb - 1);
                flt  = (req_size == 2'd3) || ((req_addr % nb) != 0) || (last >= {1'b0, LIMIT});
                lane = int'(ea[1:0]);
                word = ref_mem[ea[7:2]];
                exp_wr_cyc  = -1;
                exp_rdata   = 32'd0;
                exp_fault   = flt;
                exp_wr_addr = {ea[31:2], 2'b00};
                if (flt) begin
                    exp_rsp_cyc = cyc + 1;
                end else if (!req_write) begin
                    val = word >> (8 * lane);
                    if (nb == 1) begin
                        val &= 32'hFF;
                        if (req_signed && val[7]) val |= 32'hFFFF_FF00;
                    end else if (nb == 2) begin
                        val &= 32'hFFFF;
                        if (req_signed && val[15]) val |= 32'hFFFF_0000;
                    end
                    exp_rdata   = val;
                    exp_rsp_cyc = cyc + 2;
                end else begin
                    mask = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
                    mask = mask << (8 * lane);
                    exp_wr_data = (word & ~mask) | ((req_wdata << (8 * lane)) & mask);
                    exp_wr_cyc  = (nb == 4) ? cyc + 1 : cyc + 2;
                    exp_rsp_cyc = exp_wr_cyc + 1;
                end
                ready_from = exp_rsp_cyc + 1;
            end
        end
    end

    // Issue one request (called at posedge+1) and pin its outcome with literal expectations.
    task automatic do_req(input string name, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] x_rdata, input logic x_fault,
                          input int x_lat, input int x_wrs);
        int acc0, rsp0, wr0, n;
        acc0 = acc_count;
        rsp0 = rsp_count;
        wr0  = wr_count;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (rsp_count == rsp0 && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (acc_count != acc0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        if (rsp_count == rsp0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no response within 30 cycles", name);
        end else begin
            chk({name, "_rdata"}, last_rdata, x_rdata);
            chk({name, "_fault"}, 32'(last_fault), 32'(x_fault));
            chk({name, "_latency"}, 32'(last_rsp_cyc - last_acc_cyc), 32'(x_lat));
            chk({name, "_writes"}, 32'(wr_count - wr0), 32'(x_wrs));
        end
    endtask

    logic [31:0] b2b_addr [3] = '{32'h10, 32'h14, 32'h18};

    initial begin
        int n, k, acc0, rsp0, wr0;
        init_req   = 1'b1;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        init_req = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_w_sram_en", 32'(w_sram_en), 32'd0);
        @(posedge clk); #1;

        do_req("ldrb_s_10",  1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'hFFFF_FFA1, 1'b0, 2, 0);
        do_req("ldrh_u_12",  1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000_8765, 1'b0, 2, 0);
        do_req("ldr_10",     1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8765_43A1, 1'b0, 2, 0);
        do_req("strb_11",    1'b1, 2'd0, 1'b0, 32'h11, 32'h5A, 32'h0, 1'b0, 3, 1);
        chk("strb_11_wword", last_wdata, 32'h8765_5AA1);
        do_req("ldr_10_b",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8765_5AA1, 1'b0, 2, 0);
        do_req("ldrh_s_12",  1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFF_8765, 1'b0, 2, 0);
        do_req("ldrb_u_13",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0000_0087, 1'b0, 2, 0);
        do_req("str_mis_13", 1'b1, 2'd2, 1'b0, 32'h13, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0);
        do_req("ldr_10_c",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8765_5AA1, 1'b0, 2, 0);
        do_req("ldr_fc",     1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("size3",      1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("ldrb_fb",    1'b0, 2'd0, 1'b0, 32'hFB, 32'h0, 32'h0, 1'b0, 2, 0);
        do_req("ldrb_top",   1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("strh_16",    1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF_CAFE, 32'h0, 1'b0, 3, 1);
        chk("strh_16_wword", last_wdata, 32'hCAFE_3344);
        do_req("ldrh_u_16",  1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 32'h0000_CAFE, 1'b0, 2, 0);
        do_req("str_18",     1'b1, 2'd2, 1'b0, 32'h18, 32'h0BAD_F00D, 32'h0, 1'b0, 2, 1);
        do_req("ldr_18",     1'b0, 2'd2, 1'b0, 32'h18, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 0);

        // Reset while a halfword store sits in its write cycle.
        acc0 = acc_count;
        req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h1234; req_valid = 1'b1;
        n = 0;
        while (!w_sram_en && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (acc_count != acc0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        if (!w_sram_en) begin
            checks++;
            failures++;
            $display("FAIL abort_reach_wr: write cycle not reached within 10 cycles");
        end
        rsp0 = rsp_count;
        wr0  = wr_count;
        rst_n = 1'b0;
        #1;
        chk("abort_w_sram_en", 32'(w_sram_en), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_rsp", 32'(rsp_count - rsp0), 32'd0);
        chk("abort_no_write", 32'(wr_count - wr0), 32'd0);
        do_req("ldr_10_post", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8765_5AA1, 1'b0, 2, 0);

        // Three loads with req_valid held throughout.
        acc0 = acc_count;
        rsp0 = rsp_count;
        req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = b2b_addr[0]; req_valid = 1'b1;
        k = 0;
        n = 0;
        while ((rsp_count - rsp0) < 3 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if ((acc_count - acc0) > k) begin
                k = acc_count - acc0;
                if (k < 3) req_addr = b2b_addr[k];
                else       req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        if ((rsp_count - rsp0) < 3) begin
            checks++;
            failures++;
            $display("FAIL b2b_timeout: %0d of 3 responses", rsp_count - rsp0);
        end else begin
            chk("b2b_rsp0", rsp_log[rsp_log.size() - 3], 32'h8765_5AA1);
            chk("b2b_rsp1", rsp_log[rsp_log.size() - 2], 32'hCAFE_3344);
            chk("b2b_rsp2", rsp_log[rsp_log.size() - 1], 32'h0BAD_F00D);
            chk("b2b_spacing1", 32'(acc_log[acc_log.size() - 2] - acc_log[acc_log.size() - 3]), 32'd3);
            chk("b2b_spacing2", 32'(acc_log[acc_log.size() - 1] - acc_log[acc_log.size() - 2]), 32'd3);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
